seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Iterative ALU that executes the 4-bit ALU-control codes produced by the ALU control decoder. The codes are 0010 add, 0110 sub, 0011 xor, 0100 srl and 0101 sll. It sits in the execute stage of the multicycle RISC-V datapath. Add, sub and xor finish in one cycle; shifts use a one-bit-per-cycle shifter to save area. A start/busy/done handshake lets the control FSM stall the datapath while a shift runs.

Parameters:
WIDTH, 32, operand and result width in bits (power of two, >= 4)
SHAMT_W, $clog2(WIDTH), shift-amount width taken from b

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only on a rising edge where busy=0
aluCtrl  input  4  operation code, sampled with start
a  input  WIDTH  operand A / shift source, sampled with start
b  input  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount; upper bits ignored for shifts
busy  output  1  high while a shift is iterating (state SHIFT)
done  output  1  one-cycle pulse; result/zero/err valid from this cycle on
result  output  WIDTH  registered result, held until the next completion
zero  output  1  registered (result==0), updated with result
err  output  1  registered, 1 if the completed op code was illegal

Behaviour:
- States: IDLE, SHIFT, DONE. Reset (rst_n=0, async): state=IDLE. busy=0, done=0, result=0, zero=0, err=0. Shift register and counter are cleared.
- Start acceptance: on an edge with start=1 and state in {IDLE, DONE}, the block latches aluCtrl, a and b. start is ignored in SHIFT and no request is queued.
- add/sub/xor (0010/0110/0011):
  - next state DONE; done=1 exactly one cycle after the start edge.
  - result is a+b, a-b or a^b, modulo 2^WIDTH; no carry or overflow output.
  - err=0.
- Illegal code (anything else): next state DONE, result=0, zero=1, err=1, 1-cycle latency.
- Shifts (0100 srl logical, 0101 sll):
  - on start: load sh=a, cnt=b[SHAMT_W-1:0].
  - if cnt==0: go straight to DONE, result=a.
  - otherwise go to SHIFT. Each cycle in SHIFT: sh shifts one bit (zero fill), cnt decrements. When cnt reaches 0: result=sh, go to DONE.
  - latency from start edge to done: max(1, shamt) cycles. busy=1 for shamt-1 cycles when shamt>=2, otherwise busy=0.
- result, zero and err change only on the completion edge (entering DONE). During SHIFT they hold their previous values.
- DONE lasts one cycle. With no start it returns to IDLE, done drops to 0, and the outputs are held. A start in DONE is accepted (back-to-back); done then pulses again at that op's completion.
- Reset asserted mid-SHIFT: abort immediately, no done pulse, outputs return to reset values.
- aluCtrl/a/b changes after acceptance have no effect on the op in progress.

Test Plan:
1. Reset, then start with aluCtrl=0010, a=5, b=7 -> one cycle later done=1, result=12, zero=0, err=0, busy never 1. Next cycle done=0 and result stays 12.
2. Subtraction edge cases:
   - sub a=5, b=5 -> result=0, zero=1.
   - back-to-back start in the DONE cycle with sub a=0, b=1 -> next done has result=0xFFFFFFFF, zero=0.
3. sll a=1, b=31 -> busy high 30 cycles, done on cycle 31 after start, result=0x80000000. start pulses while busy are ignored (no extra done).
4. srl a=0x80000000, b=0x24 (shamt=4) -> done after 4 cycles, result=0x08000000. srl b=0x20 (shamt=0) -> done after 1 cycle, result=a.
5. Illegal code 0111, a=3, b=4 -> done after 1 cycle, err=1, result=0, zero=1. Following add clears err.
6. Reset mid-shift: start sll with shamt=20, assert rst_n=0 at cycle 5 -> busy, done and result drop to 0 immediately. No done pulse after release; a new add completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Iterative execute-stage ALU: add/sub/xor complete in one cycle, shifts
// walk one bit per cycle behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluCtrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;

  logic [1:0]         state_q,  state_d;
  logic               left_q,   left_d;
  logic [WIDTH-1:0]   sh_q,     sh_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q,   zero_d;
  logic               err_q,    err_d;

  logic               fin;
  logic               fin_err;
  logic [WIDTH-1:0]   fin_res;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   first_sh;
  logic [WIDTH-1:0]   step_sh;

  assign shamt    = b[SHAMT_W-1:0];
  assign first_sh = (aluCtrl == OP_SLL) ? (a << 1) : (a >> 1);
  assign step_sh  = left_q ? (sh_q << 1) : (sh_q >> 1);

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_res  = '0;

    case (state_q)
      S_SHIFT: begin
        sh_d  = step_sh;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          fin     = 1'b1;
          fin_res = step_sh;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          case (aluCtrl)
            OP_ADD: begin fin = 1'b1; fin_res = a + b; end
            OP_SUB: begin fin = 1'b1; fin_res = a - b; end
            OP_XOR: begin fin = 1'b1; fin_res = a ^ b; end
            OP_SRL, OP_SLL: begin
              left_d = (aluCtrl == OP_SLL);
              // First bit is shifted on the accepting edge so latency is
              // max(1, shamt) and busy spans only shamt-1 cycles.
              if (shamt == '0) begin
                fin     = 1'b1;
                fin_res = a;
              end else if (shamt == SHAMT_W'(1)) begin
                fin     = 1'b1;
                fin_res = first_sh;
              end else begin
                state_d = S_SHIFT;
                sh_d    = first_sh;
                cnt_d   = shamt - SHAMT_W'(1);
              end
            end
            default: begin
              fin     = 1'b1;
              fin_err = 1'b1;
              fin_res = '0;
            end
          endcase
        end
      end
    endcase

    if (fin) begin
      state_d  = S_DONE;
      result_d = fin_res;
      zero_d   = (fin_res == '0);
      err_d    = fin_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      left_q   <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed plan steps plus random ops
// compared against an arithmetic reference model.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluCtrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int unsigned vectors;
  int unsigned miscompares;

  logic [31:0] exp_res;
  logic        exp_zero;
  logic        exp_err;

  seq_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .aluCtrl (aluCtrl),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0011: return x ^ y;
      4'b0100: return x >> y[4:0];
      4'b0101: return x << y[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] c);
    return !(c == 4'b0010 || c == 4'b0110 || c == 4'b0011 || c == 4'b0100 || c == 4'b0101);
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] y);
    if (c == 4'b0100 || c == 4'b0101) return (y[4:0] == 5'd0) ? 1 : int'(y[4:0]);
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issues one op and follows it to completion; leaves time #1 after the
  // completion edge, i.e. inside the DONE cycle.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit poke);
    int lat;
    logic [31:0] r;
    lat = ref_lat(c, y);
    r   = ref_res(c, x, y);
    @(negedge clk);
    start = 1'b1; aluCtrl = c; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; aluCtrl = 4'($urandom); a = $urandom; b = $urandom;
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (i < lat) begin
        chk("busy_during_shift", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("result_hold", result, exp_res);
        if (poke) begin
          start = 1'b1; aluCtrl = 4'b0010; a = $urandom; b = $urandom;
        end
      end
    end
    exp_res  = r;
    exp_zero = (r == 32'd0);
    exp_err  = ref_err(c);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("result", result, exp_res);
    chk("zero", 32'(zero), 32'(exp_zero));
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done_low", 32'(done), 32'd0);
    chk("idle_busy_low", 32'(busy), 32'd0);
    chk("idle_result_hold", result, exp_res);
    chk("idle_zero_hold", 32'(zero), 32'(exp_zero));
    chk("idle_err_hold", 32'(err), 32'(exp_err));
  endtask

  initial begin
    bit          seen;
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  legal [5];

    vectors = 0; miscompares = 0;
    legal[0] = 4'b0010; legal[1] = 4'b0110; legal[2] = 4'b0011;
    legal[3] = 4'b0100; legal[4] = 4'b0101;
    start = 1'b0; aluCtrl = 4'd0; a = 32'd0; b = 32'd0;
    exp_res = 32'd0; exp_zero = 1'b0; exp_err = 1'b0;

    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0010, 32'd5, 32'd7, 1'b0);
    chk("add_5_7", result, 32'd12);
    idle_cycle();

    run_op(4'b0110, 32'd5, 32'd5, 1'b0);
    chk("sub_equal_zero", 32'(zero), 32'd1);
    run_op(4'b0110, 32'd0, 32'd1, 1'b0);
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    idle_cycle();

    run_op(4'b0101, 32'd1, 32'd31, 1'b1);
    chk("sll_31", result, 32'h8000_0000);
    idle_cycle();
    idle_cycle();

    run_op(4'b0100, 32'h8000_0000, 32'h24, 1'b0);
    chk("srl_4", result, 32'h0800_0000);
    idle_cycle();
    run_op(4'b0100, 32'h1234_5678, 32'h20, 1'b0);
    chk("srl_0", result, 32'h1234_5678);
    idle_cycle();
    run_op(4'b0101, 32'hC000_0001, 32'h1, 1'b0);
    idle_cycle();

    run_op(4'b0111, 32'd3, 32'd4, 1'b0);
    chk("illegal_err", 32'(err), 32'd1);
    run_op(4'b0010, 32'd3, 32'd4, 1'b0);
    chk("add_clears_err", 32'(err), 32'd0);
    idle_cycle();

    @(negedge clk);
    start = 1'b1; aluCtrl = 4'b0101; a = 32'h0000_00F1; b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_res = 32'd0; exp_zero = 1'b0; exp_err = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    run_op(4'b0010, 32'd100, 32'd23, 1'b0);
    idle_cycle();

    for (int n = 0; n < 60; n++) begin
      rc = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legal[$urandom_range(0, 4)];
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(rc, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
